// File: rtl/fc_dec_ctrl_if.sv
// BRAM port and decoder FC-core signals of the decoder-side dataflow controller.
// master = the controller, slave = BRAM mux / FC core side.
interface fc_dec_ctrl_if #(
  parameter int DIM_INPUT   = 8,
  parameter int INPUT_W     = 8,
  parameter int OUTPUT_W    = 16,
  parameter int BRAM_DAT_W  = 64,
  parameter int BRAM_ADDR_W = 32
);
  logic [BRAM_ADDR_W-1:0]       bram_addr;
  logic                         bram_en;
  logic [7:0]                   bram_we;
  logic [BRAM_DAT_W-1:0]        bram_din;
  logic [BRAM_DAT_W-1:0]        bram_dout;
  logic                         fc_in_vld;
  logic [DIM_INPUT*INPUT_W-1:0] fc_in_dat;
  logic                         fc_out_vld;
  logic [OUTPUT_W-1:0]          fc_out_dat;

  modport master (output bram_addr, bram_en, bram_we, bram_din, fc_in_vld, fc_in_dat,
                  input  bram_dout, fc_out_vld, fc_out_dat);
  modport slave  (input  bram_addr, bram_en, bram_we, bram_din, fc_in_vld, fc_in_dat,
                  output bram_dout, fc_out_vld, fc_out_dat);
endinterface

// File: rtl/fc_dec_ctrl.sv
// Decoder dataflow controller: loads latent code vectors from BRAM, feeds the FC core,
// packs its serial output into BRAM words. Optional checker: define FC_DEC_PROTO_CHK_EN.
module fc_dec_ctrl #(
  parameter int DIM_INPUT   = 8,
  parameter int DIM_OUTPUT  = 96,
  parameter int INPUT_W     = 8,
  parameter int OUTPUT_W    = 16,
  parameter int BRAM_DAT_W  = 64,
  parameter int BRAM_ADDR_W = 32,
  parameter int BATCH_NUM   = 10,
  parameter logic [BRAM_ADDR_W-1:0] LOAD_BASE  = 'h3400,
  parameter logic [BRAM_ADDR_W-1:0] STORE_BASE = 'h4000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  fc_dec_ctrl_if.master bus
);
  localparam int VEC_W      = DIM_INPUT * INPUT_W;
  localparam int LOAD_WORDS = (VEC_W + BRAM_DAT_W - 1) / BRAM_DAT_W;
  localparam int PACK       = BRAM_DAT_W / OUTPUT_W;
  localparam int LD_CW      = $clog2(LOAD_WORDS + 1);
  localparam int BEAT_W     = $clog2(DIM_OUTPUT + 1);
  localparam int LANE_W     = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int VEC_CW     = (BATCH_NUM > 1) ? $clog2(BATCH_NUM) : 1;
  localparam logic [BRAM_ADDR_W-1:0] ADDR_INC = BRAM_ADDR_W'(BRAM_DAT_W / 8);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_FEED, S_COLLECT, S_NEXT, S_DONE} state_t;

  state_t                         state_reg, state_next;
  logic [BRAM_ADDR_W-1:0]         rd_ptr_reg, wr_ptr_reg;
  logic [LD_CW-1:0]               ld_cnt_reg, cap_idx_reg;
  logic                           cap_vld_reg;
  logic [LOAD_WORDS*BRAM_DAT_W-1:0] stage_reg, cap_merged;
  logic [VEC_W-1:0]               fc_in_dat_reg;
  logic [BEAT_W-1:0]              beat_cnt_reg;
  logic [LANE_W-1:0]              lane_reg;
  logic [BRAM_DAT_W-1:0]          pack_reg, pack_merged, din_reg;
  logic                           wr_pend_reg;
  logic [VEC_CW-1:0]              vec_cnt_reg;
  logic                           beat_ok, word_full;

  // Extra beats after the vector is complete are dropped.
  assign beat_ok   = (state_reg == S_COLLECT) && bus.fc_out_vld &&
                     (beat_cnt_reg != BEAT_W'(DIM_OUTPUT));
  assign word_full = beat_ok && (lane_reg == LANE_W'(PACK - 1));

  // The incoming beat is merged combinationally so a full word can go straight to din.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign pack_merged[gi*OUTPUT_W +: OUTPUT_W] =
      (beat_ok && lane_reg == LANE_W'(gi)) ? bus.fc_out_dat : pack_reg[gi*OUTPUT_W +: OUTPUT_W];
  end

  for (genvar gi = 0; gi < LOAD_WORDS; gi++) begin : g_word
    assign cap_merged[gi*BRAM_DAT_W +: BRAM_DAT_W] =
      (cap_vld_reg && cap_idx_reg == LD_CW'(gi)) ? bus.bram_dout : stage_reg[gi*BRAM_DAT_W +: BRAM_DAT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_RD;
      S_RD:      if (ld_cnt_reg == LD_CW'(LOAD_WORDS - 1)) state_next = S_CAP;
      S_CAP:     state_next = S_FEED;
      S_FEED:    state_next = S_COLLECT;
      S_COLLECT: if (wr_pend_reg && beat_cnt_reg == BEAT_W'(DIM_OUTPUT)) state_next = S_NEXT;
      S_NEXT:    state_next = (vec_cnt_reg == VEC_CW'(BATCH_NUM - 1)) ? S_DONE : S_RD;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg    <= LOAD_BASE;
      wr_ptr_reg    <= STORE_BASE;
      ld_cnt_reg    <= '0;
      cap_vld_reg   <= 1'b0;
      cap_idx_reg   <= '0;
      stage_reg     <= '0;
      fc_in_dat_reg <= '0;
      beat_cnt_reg  <= '0;
      lane_reg      <= '0;
      pack_reg      <= '0;
      din_reg       <= '0;
      wr_pend_reg   <= 1'b0;
      vec_cnt_reg   <= '0;
    end else begin
      if (state_reg == S_IDLE && start) begin
        rd_ptr_reg  <= LOAD_BASE;
        wr_ptr_reg  <= STORE_BASE;
        vec_cnt_reg <= '0;
        ld_cnt_reg  <= '0;
      end
      if (state_reg == S_RD) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_INC;
        ld_cnt_reg <= ld_cnt_reg + LD_CW'(1);
      end
      if (state_reg == S_NEXT) begin
        ld_cnt_reg   <= '0;
        beat_cnt_reg <= '0;
        lane_reg     <= '0;
        vec_cnt_reg  <= vec_cnt_reg + VEC_CW'(1);
      end
      // Read data returns one cycle after each issue.
      cap_vld_reg <= (state_reg == S_RD);
      cap_idx_reg <= ld_cnt_reg;
      if (cap_vld_reg) stage_reg <= cap_merged;
      if (state_reg == S_CAP) fc_in_dat_reg <= cap_merged[VEC_W-1:0];
      if (beat_ok) begin
        pack_reg     <= pack_merged;
        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
        lane_reg     <= word_full ? '0 : lane_reg + LANE_W'(1);
      end
      wr_pend_reg <= word_full;
      if (word_full) din_reg <= pack_merged;
      if (wr_pend_reg) wr_ptr_reg <= wr_ptr_reg + ADDR_INC;
    end
  end

  assign bus.bram_en   = (state_reg == S_RD) || wr_pend_reg;
  assign bus.bram_we   = wr_pend_reg ? 8'hFF : 8'h00;
  assign bus.bram_addr = wr_pend_reg ? wr_ptr_reg : rd_ptr_reg;
  assign bus.bram_din  = din_reg;
  assign bus.fc_in_vld = (state_reg == S_FEED);
  assign bus.fc_in_dat = fc_in_dat_reg;
  assign busy          = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done          = (state_reg == S_DONE);

`ifdef FC_DEC_PROTO_CHK_EN
  logic err_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_reg <= 1'b0;
    else if ((bus.fc_out_vld && state_reg != S_COLLECT) || (start && busy)) err_reg <= 1'b1;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fc_dec_ctrl.sv
// Self-checking bench for fc_dec_ctrl: table of batch scenarios with random data and gaps,
// a BRAM model, a write/read scoreboard and a mid-batch reset sequence.
module tb_fc_dec_ctrl;
  localparam int BATCH   = 2;
  localparam int DIM_OUT = 96;
  localparam int PACK    = 4;
  localparam int WPV     = DIM_OUT / PACK;
  localparam logic [31:0] LOAD_BASE  = 32'h3400;
  localparam logic [31:0] STORE_BASE = 32'h4000;
`ifdef FC_DEC_PROTO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int          gap_max;
    bit          idx_vals;
    bit          start_mid;
    bit          stray;
    bit          exp_err;
    int          exp_writes;
    logic [31:0] exp_last_wr;
    logic [31:0] exp_last_rd;
  } rec_t;

  logic clk = 1'b0;
  logic rst, start, busy, done, err;

  fc_dec_ctrl_if bus ();
  fc_dec_ctrl #(.BATCH_NUM(BATCH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] mem [logic [31:0]];
  logic [63:0] load_words [BATCH];
  logic [15:0] vals [BATCH][DIM_OUT];
  logic [31:0] exp_wr_addr [$];
  logic [63:0] exp_wr_data [$];
  int          wr_idx, rd_idx, feed_idx;
  logic [31:0] last_wr, last_rd;
  logic [63:0] held_dat;
  bit          prev_busy;
  rec_t        tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BRAM with one-cycle read latency; garbage on dout when no read was issued.
  always @(posedge clk) begin
    if (bus.bram_en && bus.bram_we == 8'hFF) mem[bus.bram_addr] = bus.bram_din;
    if (bus.bram_en && bus.bram_we == 8'h00)
      bus.bram_dout <= mem.exists(bus.bram_addr) ? mem[bus.bram_addr] : 64'hBADBADBADBADBAD0;
    else
      bus.bram_dout <= {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bram_en && bus.bram_we == 8'hFF) begin
        if (wr_idx < exp_wr_addr.size()) begin
          check("wr_addr", bus.bram_addr, exp_wr_addr[wr_idx]);
          check("wr_data", bus.bram_din, exp_wr_data[wr_idx]);
        end else
          check("wr_count", wr_idx + 1, exp_wr_addr.size());
        $display("write  addr=%h data=%h", bus.bram_addr, bus.bram_din);
        last_wr = bus.bram_addr;
        wr_idx++;
      end
      if (bus.bram_en && bus.bram_we == 8'h00) begin
        check("rd_addr", bus.bram_addr, LOAD_BASE + 32'(8 * rd_idx));
        $display("read   addr=%h", bus.bram_addr);
        last_rd = bus.bram_addr;
        rd_idx++;
      end
      if (bus.bram_en && bus.bram_we != 8'h00 && bus.bram_we != 8'hFF)
        check("bram_we", bus.bram_we, 8'hFF);
      if (bus.fc_in_vld) begin
        if (feed_idx < BATCH) check("fc_in_dat", bus.fc_in_dat, load_words[feed_idx]);
        else check("feed_count", feed_idx + 1, BATCH);
        $display("feed   vec=%0d dat=%h", feed_idx, bus.fc_in_dat);
        held_dat = bus.fc_in_dat;
        feed_idx++;
      end else
        check("fc_in_hold", bus.fc_in_dat, held_dat);
      if (done) begin
        check("busy_at_done", busy, 0);
        check("busy_before_done", prev_busy, 1);
        check("writes_at_done", wr_idx, exp_wr_addr.size());
        $display("done   writes=%0d", wr_idx);
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.fc_out_vld = 1'b0;
    bus.fc_out_dat = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", bus.bram_en, 0);
    check("rst_we", bus.bram_we, 0);
    check("rst_addr", bus.bram_addr, LOAD_BASE);
    check("rst_din", bus.bram_din, 0);
    check("rst_in_vld", bus.fc_in_vld, 0);
    check("rst_in_dat", bus.fc_in_dat, 0);
    check("rst_err", err, 0);
    wr_idx = 0; rd_idx = 0; feed_idx = 0;
    held_dat = '0; prev_busy = 1'b0;
    last_wr = '0; last_rd = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic rec_t mk(input int gap, input bit idx, input bit sm, input bit st);
    rec_t r;
    r.gap_max     = gap;
    r.idx_vals    = idx;
    r.start_mid   = sm;
    r.stray       = st;
    r.exp_err     = CHK && (sm || st);
    r.exp_writes  = BATCH * DIM_OUT / PACK;
    r.exp_last_wr = STORE_BASE + 32'(BATCH * DIM_OUT * 2 - 8);
    r.exp_last_rd = LOAD_BASE + 32'(BATCH * 8 - 8);
    return r;
  endfunction

  // Reference: vector v, word j holds output values 4j..4j+3, lane 0 in the low bits.
  task automatic prepare(input rec_t r);
    logic [63:0] w;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    for (int v = 0; v < BATCH; v++) begin
      if (r.idx_vals) load_words[v] = (v == 0) ? 64'h0807060504030201 : 64'h1817161514131211;
      else            load_words[v] = {$urandom, $urandom};
      mem[LOAD_BASE + 32'(8 * v)] = load_words[v];
      for (int b = 0; b < DIM_OUT; b++)
        vals[v][b] = r.idx_vals ? 16'(b) : 16'($urandom_range(0, 65535));
      for (int j = 0; j < WPV; j++) begin
        w = '0;
        for (int k = 0; k < PACK; k++) w = w | (64'(vals[v][j*PACK+k]) << (16 * k));
        exp_wr_addr.push_back(STORE_BASE + 32'(8 * (v * WPV + j)));
        exp_wr_data.push_back(w);
      end
    end
  endtask

  task automatic run_batch(input rec_t r, input int abort_beats);
    bit found;
    prepare(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int v = 0; v < BATCH; v++) begin
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
        if (bus.bram_en && bus.bram_we == 8'h00) found = 1'b1;
        else tick();
      end
      check("rd_timeout", found, 1);
      if (!found) return;
      if (r.stray && v == 1) begin
        bus.fc_out_vld = 1'b1;
        bus.fc_out_dat = 16'hDEAD;
        tick();
        bus.fc_out_vld = 1'b0;
      end
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
        if (bus.fc_in_vld) found = 1'b1;
        else tick();
      end
      check("feed_timeout", found, 1);
      if (!found) return;
      tick();
      for (int b = 0; b < DIM_OUT; b++) begin
        if (v == 1 && b == abort_beats) return;
        repeat ($urandom_range(0, r.gap_max)) tick();
        bus.fc_out_vld = 1'b1;
        bus.fc_out_dat = vals[v][b];
        if (r.start_mid && v == 0 && b == 40) start = 1'b1;
        tick();
        bus.fc_out_vld = 1'b0;
        start = 1'b0;
      end
    end
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (done) found = 1'b1;
      else tick();
    end
    check("done_timeout", found, 1);
    // start coincident with done must not launch a new batch
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("no_restart", bus.bram_en, 0);
    check("num_writes", wr_idx, r.exp_writes);
    check("last_wr_addr", last_wr, r.exp_last_wr);
    check("last_rd_addr", last_rd, r.exp_last_rd);
    check("err", err, r.exp_err);
    if (r.idx_vals) check("first_word", mem[STORE_BASE], 64'h0003000200010000);
    for (int i = 0; i < exp_wr_addr.size(); i++)
      if (mem[exp_wr_addr[i]] !== exp_wr_data[i]) check("bram_word", mem[exp_wr_addr[i]], exp_wr_data[i]);
    $display("batch  gap=%0d start_mid=%0d stray=%0d writes=%0d err=%0d",
             r.gap_max, r.start_mid, r.stray, wr_idx, err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(0, 1'b1, 1'b0, 1'b0);
    tbl[1] = mk(3, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(2, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(1, 1'b0, 1'b0, 1'b1);
    tbl[4] = mk(0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    start = 1'b0;
    bus.fc_out_vld = 1'b0;
    bus.fc_out_dat = '0;
    #3;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_batch(tbl[i], -1);
    end
    // Abort during vector 1 collection, then restart from the base addresses.
    do_reset();
    run_batch(tbl[0], 30);
    tick();
    do_reset();
    check("busy_after_abort", busy, 0);
    run_batch(tbl[2], -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
